rps_round_controller: RTL and testbench

Round-sequencing front end for the learning rock-paper-scissors backend. Accepts one player move per round from the input layer and drives the backend's `start`/`user_choice` handshake. Captures the backend's `choice` once `ready` rises, judges the round, and keeps win/loss/tie and round counters for the display layer. It is the initiator side of the `start`/`ready` protocol that the `reinforce` learner responds to.

---
 rtl/rps_round_controller_if.sv | 11 +
 rtl/rps_round_controller.sv | 171 +++++++++++++++++
 tb/tb_rps_round_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rps_round_controller_if.sv
// Backend handshake bundle: the round controller drives start/user_choice (master),
// the learner answers with ready/comp_choice (slave).
interface rps_round_controller_if;
  logic       start;
  logic [1:0] user_choice;
  logic       ready;
  logic [1:0] comp_choice;

  modport master (output start, output user_choice, input ready, input comp_choice);
  modport slave  (input start, input user_choice, output ready, output comp_choice);
endinterface

// File: rtl/rps_round_controller.sv
// Round sequencer for the learning RPS backend: issues start/user_choice, judges the
// returned move, and keeps match statistics for the display layer.
module rps_round_controller #(
  parameter int MAX_ROUNDS = 60,
  parameter int TIMEOUT    = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [1:0]             key_choice,
  rps_round_controller_if.master bus,
  output logic [1:0]             comp_move,
  output logic [1:0]             result,
  output logic                   result_valid,
  output logic [5:0]             wins,
  output logic [5:0]             losses,
  output logic [5:0]             ties,
  output logic [5:0]             round,
  output logic                   busy,
  output logic                   done,
  output logic                   fault
);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_ACK, S_DONE, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [1:0]  user_choice_q, user_choice_d;
  logic [1:0]  comp_move_q, comp_move_d;
  logic [1:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic [5:0]  wins_q, wins_d;
  logic [5:0]  losses_q, losses_d;
  logic [5:0]  ties_q, ties_d;
  logic [5:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [15:0] tmo_q, tmo_d;

  logic [16:0] tmo_inc;
  logic        tmo_hit;
  logic [5:0]  round_inc;
  logic [1:0]  verdict;

  // Player's view: 00 tie, 01 win, 10 loss. An illegal computer move counts as a tie.
  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] r;
    r = 2'b10;
    if (c == 2'b11 || c == p) begin
      r = 2'b00;
    end else if ((p == 2'b00 && c == 2'b01) ||
                 (p == 2'b01 && c == 2'b10) ||
                 (p == 2'b10 && c == 2'b00)) begin
      r = 2'b01;
    end
    return r;
  endfunction

  assign tmo_inc   = {1'b0, tmo_q} + 17'd1;
  assign tmo_hit   = (tmo_inc == 17'(TIMEOUT));
  assign round_inc = round_q + 6'd1;
  assign verdict   = judge(user_choice_q, bus.comp_choice);

  always_comb begin
    state_d        = state_q;
    user_choice_d  = user_choice_q;
    comp_move_d    = comp_move_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    wins_d         = wins_q;
    losses_d       = losses_q;
    ties_d         = ties_q;
    round_d        = round_q;
    tmo_d          = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (key_valid && key_choice != 2'b11) begin
          user_choice_d = key_choice;
          state_d       = S_EVAL;
        end
      end
      S_EVAL: begin
        if (bus.ready) begin
          comp_move_d = bus.comp_choice;
          result_d    = verdict;
          tmo_d       = '0;
          state_d     = S_ACK;
          case (verdict)
            2'b01:   wins_d   = wins_q + 6'd1;
            2'b10:   losses_d = losses_q + 6'd1;
            default: ties_d   = ties_q + 6'd1;
          endcase
        end else begin
          tmo_d = tmo_inc[15:0];
          if (tmo_hit) state_d = S_FAULT;
        end
      end
      S_ACK: begin
        if (!bus.ready) begin
          round_d        = round_inc;
          result_valid_d = 1'b1;
          tmo_d          = '0;
          state_d        = (round_inc == 6'(MAX_ROUNDS)) ? S_DONE : S_IDLE;
        end else begin
          tmo_d = tmo_inc[15:0];
          if (tmo_hit) state_d = S_FAULT;
        end
      end
      default: begin
        // DONE and FAULT hold everything until reset
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    start_d = (state_d == S_EVAL);
    busy_d  = (state_d == S_EVAL) || (state_d == S_ACK);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      user_choice_q  <= 2'b00;
      comp_move_q    <= 2'b00;
      result_q       <= 2'b00;
      result_valid_q <= 1'b0;
      wins_q         <= '0;
      losses_q       <= '0;
      ties_q         <= '0;
      round_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      user_choice_q  <= user_choice_d;
      comp_move_q    <= comp_move_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      wins_q         <= wins_d;
      losses_q       <= losses_d;
      ties_q         <= ties_d;
      round_q        <= round_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
      tmo_q          <= tmo_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.user_choice = user_choice_q;
  assign comp_move       = comp_move_q;
  assign result          = result_q;
  assign result_valid    = result_valid_q;
  assign wins            = wins_q;
  assign losses          = losses_q;
  assign ties            = ties_q;
  assign round           = round_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_rps_round_controller.sv
// Scoreboard bench: two controllers (60-round and 4-round matches, both with a 16-cycle
// timeout) share one stimulus stream; completed rounds are checked against queued predictions.
module tb_rps_round_controller;

  logic       clock       = 1'b0;
  logic       rst_n       = 1'b0;
  logic       key_valid   = 1'b0;
  logic [1:0] key_choice  = 2'b00;
  logic       ready       = 1'b0;
  logic [1:0] comp_choice = 2'b00;

  always #5 clock = ~clock;

  rps_round_controller_if bus_a ();
  rps_round_controller_if bus_b ();
  assign bus_a.ready       = ready;
  assign bus_a.comp_choice = comp_choice;
  assign bus_b.ready       = ready;
  assign bus_b.comp_choice = comp_choice;

  logic       o_start [2];
  logic [1:0] o_uc    [2];
  logic [1:0] o_comp  [2];
  logic [1:0] o_res   [2];
  logic       o_rv    [2];
  logic [5:0] o_w     [2];
  logic [5:0] o_l     [2];
  logic [5:0] o_t     [2];
  logic [5:0] o_r     [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic       o_fault [2];

  assign o_start[0] = bus_a.start;
  assign o_start[1] = bus_b.start;
  assign o_uc[0]    = bus_a.user_choice;
  assign o_uc[1]    = bus_b.user_choice;

  rps_round_controller #(.MAX_ROUNDS(60), .TIMEOUT(16)) dut_a (
    .clock(clock), .reset(rst_n), .key_valid(key_valid), .key_choice(key_choice), .bus(bus_a),
    .comp_move(o_comp[0]), .result(o_res[0]), .result_valid(o_rv[0]),
    .wins(o_w[0]), .losses(o_l[0]), .ties(o_t[0]), .round(o_r[0]),
    .busy(o_busy[0]), .done(o_done[0]), .fault(o_fault[0])
  );

  rps_round_controller #(.MAX_ROUNDS(4), .TIMEOUT(16)) dut_b (
    .clock(clock), .reset(rst_n), .key_valid(key_valid), .key_choice(key_choice), .bus(bus_b),
    .comp_move(o_comp[1]), .result(o_res[1]), .result_valid(o_rv[1]),
    .wins(o_w[1]), .losses(o_l[1]), .ties(o_t[1]), .round(o_r[1]),
    .busy(o_busy[1]), .done(o_done[1]), .fault(o_fault[1])
  );

  typedef struct {
    logic [1:0] res;
    logic [1:0] comp;
    int         w;
    int         l;
    int         t;
    int         r;
    logic       dn;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks = 0;
  int errors = 0;

  int max_r [2] = '{60, 4};
  int m_w   [2] = '{0, 0};
  int m_l   [2] = '{0, 0};
  int m_t   [2] = '{0, 0};
  int m_r   [2] = '{0, 0};

  int   rises      [2] = '{0, 0};
  int   run_len    [2] = '{0, 0};
  int   last_run   [2] = '{0, 0};
  logic prev_start [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string n, input int i);
    return $sformatf("%s[%0d]", n, i);
  endfunction

  // Reference judge: with rock=0, scissors=1, paper=2 the player wins when c == p+1 mod 3.
  function automatic logic [1:0] ref_result(input logic [1:0] p, input logic [1:0] c);
    if (c == 2'b11 || c == p) return 2'b00;
    if (int'(c) == (int'(p) + 1) % 3) return 2'b01;
    return 2'b10;
  endfunction

  task automatic sb_compare(input int i, input exp_t e);
    $display("round done dut%0d: result=%0b comp=%0b w=%0d l=%0d t=%0d round=%0d",
             i, o_res[i], o_comp[i], o_w[i], o_l[i], o_t[i], o_r[i]);
    check(tg("sb_result", i), o_res[i], e.res);
    check(tg("sb_comp", i),   o_comp[i], e.comp);
    check(tg("sb_wins", i),   o_w[i], e.w);
    check(tg("sb_losses", i), o_l[i], e.l);
    check(tg("sb_ties", i),   o_t[i], e.t);
    check(tg("sb_round", i),  o_r[i], e.r);
    check(tg("sb_done", i),   o_done[i], e.dn);
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (o_start[i] && !prev_start[i]) begin
        rises[i]++;
        run_len[i] = 1;
      end else if (o_start[i]) begin
        run_len[i]++;
      end else if (prev_start[i]) begin
        last_run[i] = run_len[i];
      end
      prev_start[i] = o_start[i];
    end
    if (rst_n) begin
      if (o_rv[0]) begin
        if (sb_a.size() == 0) check("rv_unexpected[0]", o_rv[0], 1'b0);
        else sb_compare(0, sb_a.pop_front());
      end
      if (o_rv[1]) begin
        if (sb_b.size() == 0) check("rv_unexpected[1]", o_rv[1], 1'b0);
        else sb_compare(1, sb_b.pop_front());
      end
    end
  end

  task automatic do_reset();
    key_valid   = 1'b0;
    ready       = 1'b0;
    comp_choice = 2'b00;
    #2 rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_w[i] = 0; m_l[i] = 0; m_t[i] = 0; m_r[i] = 0;
    end
    sb_a.delete();
    sb_b.delete();
    @(negedge clock);
  endtask

  // One round: key at edge N, d EVAL edges without ready, ready edge, k ACK edges with
  // ready still high, then the ready-low edge that completes the round.
  task automatic play(input logic [1:0] p, input logic [1:0] c, input int d, input int k,
                      input bit early, input bit noise);
    logic [1:0] r;
    bit         acc [2];
    exp_t       e;
    r = ref_result(p, c);
    for (int i = 0; i < 2; i++) acc[i] = (m_r[i] < max_r[i]);
    key_valid  = 1'b1;
    key_choice = p;
    if (early) begin
      ready       = 1'b1;
      comp_choice = c;
    end
    @(negedge clock);
    key_valid  = noise;
    key_choice = 2'b01;
    for (int i = 0; i < 2; i++) begin
      check(tg("start_rise", i), o_start[i], acc[i]);
      if (acc[i]) check(tg("user_choice", i), o_uc[i], p);
    end
    repeat (d) @(negedge clock);
    ready       = 1'b1;
    comp_choice = c;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        case (r)
          2'b01:   m_w[i]++;
          2'b10:   m_l[i]++;
          default: m_t[i]++;
        endcase
        check(tg("start_fall", i), o_start[i], 1'b0);
        check(tg("early_result", i), o_res[i], r);
        check(tg("early_comp", i), o_comp[i], c);
        check(tg("early_wins", i), o_w[i], m_w[i]);
        check(tg("early_losses", i), o_l[i], m_l[i]);
        check(tg("early_ties", i), o_t[i], m_t[i]);
      end
    end
    repeat (k) @(negedge clock);
    key_valid = 1'b0;
    ready     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        m_r[i]++;
        e.res = r;  e.comp = c;
        e.w = m_w[i]; e.l = m_l[i]; e.t = m_t[i]; e.r = m_r[i];
        e.dn = (m_r[i] == max_r[i]);
        if (i == 0) sb_a.push_back(e);
        else        sb_b.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic pulse_key(input logic [1:0] p);
    key_valid  = 1'b1;
    key_choice = p;
    @(negedge clock);
    key_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [2];

    // Reset values, both while held and right after release
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("rst_start", i), o_start[i], 1'b0);
      check(tg("rst_fault", i), o_fault[i], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("rst_busy", i), o_busy[i], 1'b0);
      check(tg("rst_done", i), o_done[i], 1'b0);
      check(tg("rst_round", i), o_r[i], 6'd0);
      check(tg("rst_wins", i), o_w[i], 6'd0);
      check(tg("rst_result", i), o_res[i], 2'b00);
      check(tg("rst_uc", i), o_uc[i], 2'b00);
      check(tg("rst_rv", i), o_rv[i], 1'b0);
    end

    // Single win: paper vs rock, ready after 5 waiting cycles, dropped 2 cycles later
    play(2'b10, 2'b00, 5, 2, 1'b0, 1'b0);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("win_start_len", i), last_run[i], 6);
      check(tg("win_wins", i), o_w[i], 6'd1);
      check(tg("win_round", i), o_r[i], 6'd1);
      check(tg("win_result", i), o_res[i], 2'b01);
    end

    // Full judging matrix; the 4-round controller finishes its match partway through
    do_reset();
    for (int i = 0; i < 2; i++) base[i] = rises[i];
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) begin
        play(2'(p), 2'(c), c, p, (p == c), 1'b0);
      end
    end
    check("matrix_wins", o_w[0], 6'd3);
    check("matrix_losses", o_l[0], 6'd3);
    check("matrix_ties", o_t[0], 6'd3);
    check("matrix_round", o_r[0], 6'd9);
    check("matrix_rises", rises[0] - base[0], 9);
    check("end_done", o_done[1], 1'b1);
    check("end_round", o_r[1], 6'd4);
    check("end_rises", rises[1] - base[1], 4);
    pulse_key(2'b00);
    repeat (2) @(negedge clock);
    check("end_start", o_start[1], 1'b0);
    check("end_busy", o_busy[1], 1'b0);
    check("end_round_after", o_r[1], 6'd4);
    check("end_wins_after", o_w[1], m_w[1]);
    check("end_losses_after", o_l[1], m_l[1]);
    check("end_ties_after", o_t[1], m_t[1]);

    // Keys during EVAL/ACK are dropped, illegal computer move scores a tie, key 11 ignored
    do_reset();
    for (int i = 0; i < 2; i++) base[i] = rises[i];
    play(2'b01, 2'b11, 3, 3, 1'b0, 1'b1);
    pulse_key(2'b11);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("drop_start", i), o_start[i], 1'b0);
      check(tg("drop_busy", i), o_busy[i], 1'b0);
      check(tg("drop_round", i), o_r[i], 6'd1);
      check(tg("drop_rises", i), rises[i] - base[i], 1);
    end

    // Timeout in EVAL: ready never rises
    do_reset();
    pulse_key(2'b00);
    for (int j = 1; j <= 16; j++) begin
      for (int i = 0; i < 2; i++) begin
        check(tg($sformatf("tmo_eval_start_c%0d", j), i), o_start[i], 1'b1);
        check(tg($sformatf("tmo_eval_fault_c%0d", j), i), o_fault[i], 1'b0);
      end
      @(negedge clock);
    end
    for (int i = 0; i < 2; i++) begin
      check(tg("tmo_eval_fault", i), o_fault[i], 1'b1);
      check(tg("tmo_eval_start", i), o_start[i], 1'b0);
      check(tg("tmo_eval_busy", i), o_busy[i], 1'b0);
    end
    pulse_key(2'b10);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("tmo_key_start", i), o_start[i], 1'b0);
      check(tg("tmo_key_fault", i), o_fault[i], 1'b1);
      check(tg("tmo_key_round", i), o_r[i], 6'd0);
    end

    // Timeout in ACK: ready stuck high after the computer answers (rock vs rock)
    do_reset();
    ready       = 1'b1;
    comp_choice = 2'b00;
    pulse_key(2'b00);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("ack_start", i), o_start[i], 1'b0);
      check(tg("ack_ties", i), o_t[i], 6'd1);
    end
    repeat (15) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("ack_nofault", i), o_fault[i], 1'b0);
      check(tg("ack_busy", i), o_busy[i], 1'b1);
    end
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("ack_fault", i), o_fault[i], 1'b1);
      check(tg("ack_fault_busy", i), o_busy[i], 1'b0);
    end
    ready = 1'b0;
    pulse_key(2'b01);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check(tg("ack_frozen_round", i), o_r[i], 6'd0);
      check(tg("ack_frozen_ties", i), o_t[i], 6'd1);
      check(tg("ack_key_start", i), o_start[i], 1'b0);
    end

    // Reset mid-EVAL after one completed round
    do_reset();
    play(2'b00, 2'b01, 1, 1, 1'b0, 1'b0);
    pulse_key(2'b10);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check(tg("mid_rst_start", i), o_start[i], 1'b0);
      check(tg("mid_rst_round", i), o_r[i], 6'd0);
      check(tg("mid_rst_wins", i), o_w[i], 6'd0);
      check(tg("mid_rst_busy", i), o_busy[i], 1'b0);
    end
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_w[i] = 0; m_l[i] = 0; m_t[i] = 0; m_r[i] = 0;
    end
    sb_a.delete();
    sb_b.delete();
    @(negedge clock);
    play(2'b01, 2'b10, 0, 0, 1'b0, 1'b0);
    @(negedge clock);
    for (int i = 0; i < 2; i++) check(tg("post_rst_round", i), o_r[i], 6'd1);

    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
